// File: rtl/xcvr_tx_lane_reset_seq.sv
// TX lane reset sequencer: waits for stable PLL lock, releases PMA then PCS resets,
// re-sequences on lock loss and retries lock timeouts up to a sticky fault.
module xcvr_tx_lane_reset_seq #(
    parameter int unsigned SYNC_STAGES         = 2,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned PMA_SETTLE_CYCLES   = 64,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned TIMER_W             = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       pll_lock_async,
    input  logic       tx_clk_stable_async,
    output logic       pma_arst_n,
    output logic       pcs_arst_n,
    output logic       tx_ready,
    output logic       fault,
    output logic [2:0] state_o,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_lost_cnt
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StPmaRel   = 3'd3,
        StReady    = 3'd4,
        StFault    = 3'd5
    } state_e;

    localparam logic [TIMER_W-1:0] StableLast  = TIMER_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SettleLast  = TIMER_W'(PMA_SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TimeoutLast = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TimerOne    = TIMER_W'(1);
    localparam logic [3:0]         MaxRetries  = 4'(MAX_RETRIES);

    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic [SYNC_STAGES-1:0] stb_sync_q;
    logic                   pll_lock_s;
    logic                   clk_stable_s;

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [3:0]           retry_q, retry_d;
    logic [7:0]           lost_q, lost_d;
    logic                 pma_q, pma_d;
    logic                 pcs_q, pcs_d;
    logic                 ready_q, ready_d;
    logic                 fault_q, fault_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_sync_q <= '0;
            stb_sync_q  <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_lock_async};
            stb_sync_q  <= {stb_sync_q[SYNC_STAGES-2:0], tx_clk_stable_async};
        end
    end

    assign pll_lock_s   = lock_sync_q[SYNC_STAGES-1];
    assign clk_stable_s = stb_sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
        lost_d  = lost_q;
        if (!enable) begin
            state_d = StIdle;
            timer_d = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StWaitLock;
                    timer_d = '0;
                end
                StWaitLock: begin
                    if (pll_lock_s) begin
                        state_d = StStable;
                        timer_d = '0;
                    end else if (timer_q == TimeoutLast) begin
                        if (retry_q == MaxRetries) begin
                            state_d = StFault;
                        end else begin
                            retry_d = retry_q + 4'd1;
                            timer_d = '0;
                        end
                    end else begin
                        timer_d = timer_q + TimerOne;
                    end
                end
                StStable: begin
                    // A drop before PMA release is just an unstable lock, not a loss.
                    if (!pll_lock_s) begin
                        state_d = StWaitLock;
                        timer_d = '0;
                    end else if (timer_q == StableLast) begin
                        state_d = StPmaRel;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TimerOne;
                    end
                end
                StPmaRel, StReady: begin
                    if (!pll_lock_s) begin
                        state_d = StWaitLock;
                        timer_d = '0;
                        if (lost_q != 8'hff) lost_d = lost_q + 8'd1;
                    end else if (state_q == StPmaRel) begin
                        if (timer_q == SettleLast) begin
                            if (clk_stable_s) begin
                                state_d = StReady;
                                timer_d = '0;
                            end
                        end else begin
                            timer_d = timer_q + TimerOne;
                        end
                    end
                end
                StFault: ;
                default: begin
                    state_d = StIdle;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Output flops load the decode of the next state so they track state_q exactly.
    always_comb begin
        pma_d   = 1'b0;
        pcs_d   = 1'b0;
        ready_d = 1'b0;
        fault_d = 1'b0;
        case (state_d)
            StPmaRel: pma_d = 1'b1;
            StReady: begin
                pma_d   = 1'b1;
                pcs_d   = 1'b1;
                ready_d = 1'b1;
            end
            StFault: fault_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            timer_q <= '0;
            retry_q <= '0;
            lost_q  <= '0;
            pma_q   <= 1'b0;
            pcs_q   <= 1'b0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            lost_q  <= lost_d;
            pma_q   <= pma_d;
            pcs_q   <= pcs_d;
            ready_q <= ready_d;
            fault_q <= fault_d;
        end
    end

    assign pma_arst_n    = pma_q;
    assign pcs_arst_n    = pcs_q;
    assign tx_ready      = ready_q;
    assign fault         = fault_q;
    assign state_o       = state_q;
    assign retry_cnt     = retry_q;
    assign lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_xcvr_tx_lane_reset_seq.sv
// Directed bench for xcvr_tx_lane_reset_seq: per-row stimulus with expected outputs after
// a fixed number of edges, plus hand sequences for clock-stable gating and count saturation.
module tb_xcvr_tx_lane_reset_seq;

    logic       clk = 1'b0;
    logic       reset, enable, lock_a, stb_a;
    logic       pma_arst_n, pcs_arst_n, tx_ready, fault;
    logic [2:0] state_o;
    logic [3:0] retry_cnt;
    logic [7:0] lock_lost_cnt;

    int tests  = 0;
    int failed = 0;

    xcvr_tx_lane_reset_seq #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (8),
        .PMA_SETTLE_CYCLES  (4),
        .LOCK_TIMEOUT_CYCLES(16),
        .MAX_RETRIES        (2),
        .TIMER_W            (20)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .pll_lock_async     (lock_a),
        .tx_clk_stable_async(stb_a),
        .pma_arst_n         (pma_arst_n),
        .pcs_arst_n         (pcs_arst_n),
        .tx_ready           (tx_ready),
        .fault              (fault),
        .state_o            (state_o),
        .retry_cnt          (retry_cnt),
        .lock_lost_cnt      (lock_lost_cnt)
    );

    always #5 clk = ~clk;

    // {state, pma, pcs, ready, fault, retry, lost}
    typedef struct {
        logic        rst;
        logic        en;
        logic        lock;
        logic        stb;
        int          n;
        logic [18:0] exp;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic rst, input logic en, input logic lk, input logic sb,
                                input int n, input logic [2:0] st, input logic pma,
                                input logic pcs, input logic rdy, input logic flt,
                                input logic [3:0] rt, input logic [7:0] lost);
        vec_t v;
        v.rst  = rst;
        v.en   = en;
        v.lock = lk;
        v.stb  = sb;
        v.n    = n;
        v.exp  = {st, pma, pcs, rdy, flt, rt, lost};
        return v;
    endfunction

    function automatic logic [18:0] obs();
        return {state_o, pma_arst_n, pcs_arst_n, tx_ready, fault, retry_cnt, lock_lost_cnt};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        lock_a = 1'b0;
        stb_a  = 1'b0;

        // Bring-up with lock and clock-stable high from the start
        vq.push_back(mk(1, 0, 0, 0, 3, 3'd0, 0, 0, 0, 0, 4'd0, 8'd0));
        vq.push_back(mk(0, 1, 1, 1, 1, 3'd1, 0, 0, 0, 0, 4'd0, 8'd0));
        vq.push_back(mk(0, 1, 1, 1, 9, 3'd2, 0, 0, 0, 0, 4'd0, 8'd0));
        vq.push_back(mk(0, 1, 1, 1, 1, 3'd3, 1, 0, 0, 0, 4'd0, 8'd0));
        vq.push_back(mk(0, 1, 1, 1, 3, 3'd3, 1, 0, 0, 0, 4'd0, 8'd0));
        vq.push_back(mk(0, 1, 1, 1, 1, 3'd4, 1, 1, 1, 0, 4'd0, 8'd0));
        // One-cycle lock drop in READY, then re-sequence
        vq.push_back(mk(0, 1, 0, 1, 1, 3'd4, 1, 1, 1, 0, 4'd0, 8'd0));
        vq.push_back(mk(0, 1, 1, 1, 1, 3'd4, 1, 1, 1, 0, 4'd0, 8'd0));
        vq.push_back(mk(0, 1, 1, 1, 1, 3'd1, 0, 0, 0, 0, 4'd0, 8'd1));
        vq.push_back(mk(0, 1, 1, 1, 1, 3'd2, 0, 0, 0, 0, 4'd0, 8'd1));
        vq.push_back(mk(0, 1, 1, 1, 7, 3'd2, 0, 0, 0, 0, 4'd0, 8'd1));
        vq.push_back(mk(0, 1, 1, 1, 1, 3'd3, 1, 0, 0, 0, 4'd0, 8'd1));
        vq.push_back(mk(0, 1, 1, 1, 4, 3'd4, 1, 1, 1, 0, 4'd0, 8'd1));
        // Disable, flush synchronizers, then a short lock pulse during STABLE
        vq.push_back(mk(0, 0, 1, 1, 1, 3'd0, 0, 0, 0, 0, 4'd0, 8'd1));
        vq.push_back(mk(0, 0, 0, 1, 3, 3'd0, 0, 0, 0, 0, 4'd0, 8'd1));
        vq.push_back(mk(0, 1, 1, 1, 5, 3'd2, 0, 0, 0, 0, 4'd0, 8'd1));
        vq.push_back(mk(0, 1, 0, 1, 2, 3'd2, 0, 0, 0, 0, 4'd0, 8'd1));
        vq.push_back(mk(0, 1, 0, 1, 1, 3'd1, 0, 0, 0, 0, 4'd0, 8'd1));
        vq.push_back(mk(0, 1, 1, 1, 2, 3'd1, 0, 0, 0, 0, 4'd0, 8'd1));
        vq.push_back(mk(0, 1, 1, 1, 1, 3'd2, 0, 0, 0, 0, 4'd0, 8'd1));
        vq.push_back(mk(0, 1, 1, 1, 7, 3'd2, 0, 0, 0, 0, 4'd0, 8'd1));
        vq.push_back(mk(0, 1, 1, 1, 1, 3'd3, 1, 0, 0, 0, 4'd0, 8'd1));
        vq.push_back(mk(0, 1, 1, 1, 4, 3'd4, 1, 1, 1, 0, 4'd0, 8'd1));
        // Lock never arrives: two retries then FAULT on the third timeout
        vq.push_back(mk(0, 0, 0, 1, 3, 3'd0, 0, 0, 0, 0, 4'd0, 8'd1));
        vq.push_back(mk(0, 1, 0, 1, 16, 3'd1, 0, 0, 0, 0, 4'd0, 8'd1));
        vq.push_back(mk(0, 1, 0, 1, 1, 3'd1, 0, 0, 0, 0, 4'd1, 8'd1));
        vq.push_back(mk(0, 1, 0, 1, 15, 3'd1, 0, 0, 0, 0, 4'd1, 8'd1));
        vq.push_back(mk(0, 1, 0, 1, 1, 3'd1, 0, 0, 0, 0, 4'd2, 8'd1));
        vq.push_back(mk(0, 1, 0, 1, 15, 3'd1, 0, 0, 0, 0, 4'd2, 8'd1));
        vq.push_back(mk(0, 1, 0, 1, 1, 3'd5, 0, 0, 0, 1, 4'd2, 8'd1));
        vq.push_back(mk(0, 1, 1, 1, 5, 3'd5, 0, 0, 0, 1, 4'd2, 8'd1));
        vq.push_back(mk(0, 0, 1, 1, 1, 3'd0, 0, 0, 0, 0, 4'd0, 8'd1));

        for (int i = 0; i < vq.size(); i++) begin
            reset  = vq[i].rst;
            enable = vq[i].en;
            lock_a = vq[i].lock;
            stb_a  = vq[i].stb;
            step(vq[i].n);
            chk($sformatf("vec[%0d]", i), 32'(obs()), 32'(vq[i].exp));
        end

        // PCS release gated by clock-stable
        enable = 1'b0;
        stb_a  = 1'b0;
        step(3);
        enable = 1'b1;
        step(30);
        chk("stb_low_state", 32'(state_o), 32'd3);
        chk("stb_low_pma_pcs", 32'({pma_arst_n, pcs_arst_n}), 32'b10);
        stb_a = 1'b1;
        step(2);
        chk("stb_rise_not_yet", 32'(tx_ready), 32'd0);
        step(1);
        chk("stb_rise_ready", 32'({state_o, pcs_arst_n, tx_ready}), 32'({3'd4, 2'b11}));

        // Repeated lock losses saturate the counter at 255
        for (int i = 0; i < 300; i++) begin
            lock_a = 1'b0;
            step(1);
            lock_a = 1'b1;
            step(15);
            if (i == 252) chk("lost_254", 32'(lock_lost_cnt), 32'd254);
            if (i == 253) chk("lost_255", 32'(lock_lost_cnt), 32'd255);
        end
        chk("lost_sat", 32'({state_o, lock_lost_cnt}), 32'({3'd4, 8'd255}));
        enable = 1'b0;
        step(2);
        chk("lost_kept_by_disable", 32'({state_o, lock_lost_cnt}), 32'({3'd0, 8'd255}));
        reset = 1'b1;
        step(1);
        chk("lost_cleared_by_reset", 32'(obs()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/xcvr_tx_lane_reset_seq.md
Name: xcvr_tx_lane_reset_seq

Overview:
- Fabric-side reset sequencer downstream of the transceiver TX PLL.
- Consumes the PLL's asynchronous fabric lock indication. Sequences the TX lane's PMA and PCS resets after lock is stable, then reports lane-ready to the video TX path.
- Detects loss of lock, re-runs the sequence, retries on lock timeout and flags a sticky fault.

Parameters:
- SYNC_STAGES, 2, flops in each input synchronizer (min 2)
- LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before PMA release (min 1)
- PMA_SETTLE_CYCLES, 64, minimum cycles in PMA_REL before PCS release (min 1)
- LOCK_TIMEOUT_CYCLES, 65536, cycles allowed in WAIT_LOCK before a retry (min 2)
- MAX_RETRIES, 3, timeouts tolerated before FAULT (0..15)
- TIMER_W, 20, internal timer width; every *_CYCLES parameter must be <= 2^TIMER_W

Ports:
- clk  in  1  fabric clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  level; 1 = run sequence, 0 = hold lane in reset
- pll_lock_async  in  1  TX PLL fabric lock, asynchronous to clk
- tx_clk_stable_async  in  1  lane TX clock stable, asynchronous to clk
- pma_arst_n  out  1  lane PMA reset, active-low
- pcs_arst_n  out  1  lane PCS reset, active-low
- tx_ready  out  1  lane usable
- fault  out  1  sticky retry exhaustion
- state_o  out  3  current state encoding
- retry_cnt  out  4  timeouts since last IDLE
- lock_lost_cnt  out  8  saturating count of lock losses after PMA release

Behaviour:
- Both async inputs pass through SYNC_STAGES-flop synchronizers, giving pll_lock_s and clk_stable_s. Synchronizer flops reset to 0.
- All outputs are registered Moore decodes of the state register.
- Reset values: state = IDLE(0), pma_arst_n = 0, pcs_arst_n = 0, tx_ready = 0, fault = 0, retry_cnt = 0, lock_lost_cnt = 0, timer = 0.
- Per-state outputs:
  - IDLE(0), WAIT_LOCK(1), STABLE(2), FAULT(5): pma = 0, pcs = 0, ready = 0.
  - PMA_REL(3): pma = 1, pcs = 0, ready = 0.
  - READY(4): pma = 1, pcs = 1, ready = 1.
  - fault = 1 only in FAULT.
- Priority at every edge: reset > enable = 0 > per-state rules.
  - enable = 0 in any state → IDLE next cycle, timer = 0, retry_cnt = 0.
- IDLE: enable = 1 → WAIT_LOCK, timer = 0.
- WAIT_LOCK:
  - pll_lock_s = 1 → STABLE, timer = 0.
  - Otherwise, if timer == LOCK_TIMEOUT_CYCLES-1:
    - retry_cnt == MAX_RETRIES → FAULT.
    - else retry_cnt++, timer = 0, stay in WAIT_LOCK.
  - Otherwise timer++.
- STABLE:
  - pll_lock_s = 0 → WAIT_LOCK, timer = 0. Not counted as a retry or a loss.
  - Else if timer == LOCK_STABLE_CYCLES-1 → PMA_REL, timer = 0.
  - Else timer++.
- PMA_REL: timer++ saturating at PMA_SETTLE_CYCLES-1. Move to READY when timer == PMA_SETTLE_CYCLES-1 and clk_stable_s = 1.
- READY: hold.
- Loss of lock:
  - pll_lock_s = 0 in PMA_REL or READY → WAIT_LOCK, timer = 0, lock_lost_cnt++ saturating at 255.
  - Resets reassert and tx_ready drops on the same edge the state changes.
  - retry_cnt is unchanged.
- Lock loss and the PMA_REL→READY condition on the same edge: lock loss wins.
- FAULT: sticky until enable = 0 or reset. Ignores pll_lock_s.
- Latency: from the first clk edge sampling pll_lock_async = 1 (held high) starting in WAIT_LOCK:
  - pma_arst_n rises after SYNC_STAGES + LOCK_STABLE_CYCLES + 1 edges.
  - pcs_arst_n and tx_ready rise after a further PMA_SETTLE_CYCLES edges when clk_stable_s is already 1; otherwise 1 edge after clk_stable_s rises.
- lock_lost_cnt is cleared only by reset, not by enable.
- State encodings 6–7 are illegal and return to IDLE.

Test Plan:
- Timing params: LOCK_STABLE = 8, PMA_SETTLE = 4, TIMEOUT = 16, MAX_RETRIES = 2.
- Reset held 3 cycles, then enable = 1, pll_lock_async and tx_clk_stable_async high from the start → pma_arst_n rises 11 edges after the first lock-sampling edge in WAIT_LOCK; pcs_arst_n and tx_ready rise 4 edges later; state_o = 4.
- pll_lock_async pulses high 5 cycles then low during STABLE, then goes high permanently → returns to WAIT_LOCK; the full 8-cycle stable count restarts; retry_cnt = 0; lock_lost_cnt = 0.
- In READY, drop pll_lock_async for 1 cycle → all outputs deassert SYNC_STAGES+1 edges later; lock_lost_cnt = 1; sequence completes again with the same latency as scenario 1.
- pll_lock_async held low → retry_cnt steps 1, 2 at 16-cycle intervals; FAULT after the third timeout (edge 48); fault = 1. Then enable = 0 → IDLE, fault = 0, retry_cnt = 0.
- tx_clk_stable_async low through PMA_REL for 20 cycles → pma_arst_n = 1, pcs_arst_n = 0. Raise it → tx_ready rises SYNC_STAGES+1 edges later.
- 300 lock losses in READY → lock_lost_cnt saturates at 255. Then enable = 0 → count stays 255; reset → 0.
